psum_writeback: RTL and testbench

- Downstream stage of the corelet; drains completed psum vectors from the OFIFO read port (ofifo_valid/ofifo_rd/ofifo_rdata) into the psum SRAM.
- Writes each vector to consecutive addresses starting at a programmed base.
- Provides start/busy/done handshake, SRAM-arbitration stall and abort for the top-level controller.
- Pure sequencer: no arithmetic on psum data; SFP accumulation is outside this block.

---
 rtl/psum_writeback_if.sv | 25 ++
 rtl/psum_writeback.sv | 137 +++++++++++++
 tb/tb_psum_writeback.sv | 251 +++++++++++++++++++++++++
 3 files changed

// File: rtl/psum_writeback_if.sv
// Bus between psum_writeback and its neighbours.
// Carries the OFIFO read port and the psum SRAM write port.
interface psum_writeback_if #(
    parameter int psum_bw = 16,
    parameter int col     = 8,
    parameter int addr_bw = 11
);
    logic                     ofifo_valid;
    logic                     ofifo_rd;
    logic [psum_bw*col-1:0]   ofifo_rdata;
    logic                     sram_cen;
    logic                     sram_wen;
    logic [addr_bw-1:0]       sram_addr;
    logic [psum_bw*col-1:0]   sram_wdata;

    modport master (
        input  ofifo_valid, ofifo_rdata,
        output ofifo_rd, sram_cen, sram_wen, sram_addr, sram_wdata
    );

    modport slave (
        output ofifo_valid, ofifo_rdata,
        input  ofifo_rd, sram_cen, sram_wen, sram_addr, sram_wdata
    );
endinterface

// File: rtl/psum_writeback.sv
// Drains completed psum vectors from the OFIFO into consecutive psum SRAM addresses.
// The sequencer does no arithmetic on the data; each pop becomes one registered SRAM write.
module psum_writeback #(
    parameter int psum_bw = 16,
    parameter int col     = 8,
    parameter int addr_bw = 11,
    parameter int cnt_bw  = 11
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [addr_bw-1:0] base_addr,
    input  logic [cnt_bw-1:0]  num_vec,
    input  logic               abort,
    input  logic               sram_busy,
    psum_writeback_if.master   wb,
    output logic               busy,
    output logic               done,
    output logic [cnt_bw-1:0]  wr_count
);
    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        DRAIN = 2'b01,
        FLUSH = 2'b10
    } state_t;

    localparam logic [cnt_bw-1:0]  cnt_zero  = {cnt_bw{1'b0}};
    localparam logic [cnt_bw-1:0]  cnt_one   = {{(cnt_bw-1){1'b0}}, 1'b1};
    localparam logic [addr_bw-1:0] addr_zero = {addr_bw{1'b0}};
    localparam logic [addr_bw-1:0] addr_one  = {{(addr_bw-1){1'b0}}, 1'b1};

    state_t                   state_r, next_state_s;
    logic                     pop_s;
    logic                     accept_s;
    logic [addr_bw-1:0]       base_r;
    logic [cnt_bw-1:0]        remaining_r;
    logic [addr_bw-1:0]       index_r;
    logic [cnt_bw-1:0]        wr_count_r;
    logic                     cen_r;
    logic                     wen_r;
    logic [addr_bw-1:0]       addr_r;
    logic [psum_bw*col-1:0]   wdata_r;
    logic                     busy_r;
    logic                     done_r;

    // Next-state and pop decision; abort suppresses the pop and ends the job.
    always_comb begin
        next_state_s = state_r;
        pop_s        = 1'b0;
        accept_s     = 1'b0;
        case (state_r)
            IDLE: begin
                if (start) begin
                    accept_s     = 1'b1;
                    next_state_s = (num_vec == cnt_zero) ? FLUSH : DRAIN;
                end else begin
                    next_state_s = IDLE;
                end
            end
            DRAIN: begin
                pop_s = wb.ofifo_valid & ~sram_busy & ~abort;
                if (abort) begin
                    next_state_s = FLUSH;
                end else if (pop_s && (remaining_r == cnt_one)) begin
                    next_state_s = FLUSH;
                end else begin
                    next_state_s = DRAIN;
                end
            end
            FLUSH:   next_state_s = IDLE;
            default: next_state_s = IDLE;
        endcase
    end

    // State register; busy/done are registered copies of the next-state decode.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= IDLE;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            state_r <= next_state_s;
            busy_r  <= (next_state_s != IDLE);
            done_r  <= (next_state_s == FLUSH);
        end
    end

    // Job bookkeeping: base, vectors left, write index and the visible count.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            base_r      <= addr_zero;
            remaining_r <= cnt_zero;
            index_r     <= addr_zero;
            wr_count_r  <= cnt_zero;
        end else if (accept_s) begin
            base_r      <= base_addr;
            remaining_r <= num_vec;
            index_r     <= addr_zero;
            wr_count_r  <= cnt_zero;
        end else if (pop_s) begin
            remaining_r <= remaining_r - cnt_one;
            index_r     <= index_r + addr_one;
            wr_count_r  <= wr_count_r + cnt_one;
        end else begin
            remaining_r <= remaining_r;
            index_r     <= index_r;
            wr_count_r  <= wr_count_r;
        end
    end

    // SRAM write port: a pop in one cycle becomes the write in the next; idle cycles hold addr/data.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cen_r   <= 1'b1;
            wen_r   <= 1'b1;
            addr_r  <= addr_zero;
            wdata_r <= {(psum_bw*col){1'b0}};
        end else if (pop_s) begin
            cen_r   <= 1'b0;
            wen_r   <= 1'b0;
            addr_r  <= base_r + index_r;
            wdata_r <= wb.ofifo_rdata;
        end else begin
            cen_r   <= 1'b1;
            wen_r   <= 1'b1;
        end
    end

    assign wb.ofifo_rd    = pop_s;
    assign wb.sram_cen    = cen_r;
    assign wb.sram_wen    = wen_r;
    assign wb.sram_addr   = addr_r;
    assign wb.sram_wdata  = wdata_r;
    assign busy           = busy_r;
    assign done           = done_r;
    assign wr_count       = wr_count_r;
endmodule

// File: tb/tb_psum_writeback.sv
// Directed and randomized bench for psum_writeback against a job-level reference model.
module tb_psum_writeback;
    localparam int PBW = 16;
    localparam int COL = 8;
    localparam int ABW = 11;
    localparam int CBW = 11;
    localparam int VW  = PBW * COL;

    logic           clk = 1'b0;
    logic           reset;
    logic           start;
    logic [ABW-1:0] base_addr;
    logic [CBW-1:0] num_vec;
    logic           abort;
    logic           sram_busy;
    logic           busy;
    logic           done;
    logic [CBW-1:0] wr_count;

    always #5 clk = ~clk;

    psum_writeback_if #(.psum_bw(PBW), .col(COL), .addr_bw(ABW)) wbif ();

    psum_writeback #(.psum_bw(PBW), .col(COL), .addr_bw(ABW), .cnt_bw(CBW)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .base_addr (base_addr),
        .num_vec   (num_vec),
        .abort     (abort),
        .sram_busy (sram_busy),
        .wb        (wbif.master),
        .busy      (busy),
        .done      (done),
        .wr_count  (wr_count)
    );

    int compared   = 0;
    int mismatched = 0;

    // Reference model: OFIFO contents plus job-level progress.
    logic [VW-1:0]  fifo_q[$];
    bit             m_drain;
    bit             m_flush;
    int             m_pops;
    int             m_left;
    logic [ABW-1:0] m_base;
    int             job_writes;
    int             job_dones;

    function automatic logic [VW-1:0] rand_vec();
        logic [VW-1:0] v;
        for (int i = 0; i < VW / 32; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    task automatic chk(input string tag, input logic [VW-1:0] obs, input logic [VW-1:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push_n(input int n);
        for (int i = 0; i < n; i++) fifo_q.push_back(rand_vec());
    endtask

    task automatic chk_reset_values();
        chk("rst_ofifo_rd", wbif.ofifo_rd, 1'b0);
        chk("rst_sram_cen", wbif.sram_cen, 1'b1);
        chk("rst_sram_wen", wbif.sram_wen, 1'b1);
        chk("rst_sram_addr", wbif.sram_addr, '0);
        chk("rst_sram_wdata", wbif.sram_wdata, '0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_wr_count", wr_count, '0);
    endtask

    // One clock cycle: drive inputs, check the pop decision, advance, check the write port.
    task automatic cycle(input bit st, input int b, input int n, input bit ab, input bit sb, input bit ve);
        logic [VW-1:0]  head;
        logic [ABW-1:0] exp_addr;
        bit             exp_rd;
        logic           rd_seen;
        start     = st;
        base_addr = ABW'(b);
        num_vec   = CBW'(n);
        abort     = ab;
        sram_busy = sb;
        wbif.ofifo_valid = ve && (fifo_q.size() > 0);
        head = wbif.ofifo_valid ? fifo_q[0] : '0;
        wbif.ofifo_rdata = head;
        #1;
        exp_rd  = m_drain && wbif.ofifo_valid && !sb && !ab;
        rd_seen = wbif.ofifo_rd;
        chk("ofifo_rd", rd_seen, exp_rd);
        @(posedge clk);
        #1;
        if (rd_seen === 1'b1 && fifo_q.size() > 0) void'(fifo_q.pop_front());
        if (m_flush) begin
            m_flush = 1'b0;
        end else if (m_drain) begin
            if (exp_rd) begin
                m_pops++;
                m_left--;
            end
            if (ab || m_left == 0) begin
                m_drain = 1'b0;
                m_flush = 1'b1;
            end
        end else if (st) begin
            m_base  = ABW'(b);
            m_left  = n;
            m_pops  = 0;
            m_drain = (n != 0);
            m_flush = (n == 0);
        end
        chk("sram_cen", wbif.sram_cen, !exp_rd);
        chk("sram_wen", wbif.sram_wen, !exp_rd);
        if (exp_rd) begin
            exp_addr = m_base + ABW'(m_pops - 1);
            chk("sram_addr", wbif.sram_addr, exp_addr);
            chk("sram_wdata", wbif.sram_wdata, head);
        end
        chk("busy", busy, m_drain || m_flush);
        chk("done", done, m_flush);
        chk("wr_count", wr_count, CBW'(m_pops));
        if (wbif.sram_cen === 1'b0) job_writes++;
        if (done === 1'b1) job_dones++;
    endtask

    task automatic begin_job(input int b, input int n);
        job_writes = 0;
        job_dones  = 0;
        cycle(1'b1, b, n, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic finish_job();
        int guard = 0;
        while ((m_drain || m_flush) && guard < 100) begin
            cycle(1'b0, 0, 0, 1'b0, 1'b0, 1'b1);
            guard++;
        end
        if (guard >= 100) begin
            chk("job_timeout", 1'b1, 1'b0);
            m_drain = 1'b0;
            m_flush = 1'b0;
        end
        chk("job_writes", job_writes, m_pops);
        chk("job_dones", job_dones, 1);
    endtask

    initial begin
        int n;
        bit ve, sb, ab;
        bit vld_pat[5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        bit sb_pat[5]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};

        reset = 1'b0; start = 1'b0; base_addr = '0; num_vec = '0;
        abort = 1'b0; sram_busy = 1'b0;
        wbif.ofifo_valid = 1'b0; wbif.ofifo_rdata = '0;
        m_drain = 1'b0; m_flush = 1'b0; m_pops = 0; m_left = 0; m_base = '0;
        #12;
        chk_reset_values();
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;

        // Basic drain of four vectors.
        push_n(4);
        begin_job(12'h010, 4);
        finish_job();
        chk("basic_wr_count", wr_count, 11'd4);
        cycle(1'b0, 0, 0, 1'b0, 1'b0, 1'b0);
        chk("basic_busy_after", busy, 1'b0);

        // Backpressure: gaps in valid plus one SRAM-busy cycle.
        push_n(3);
        begin_job(12'h0A0, 3);
        for (int i = 0; i < 5; i++) cycle(1'b0, 0, 0, 1'b0, sb_pat[i], vld_pat[i]);
        finish_job();

        // Address wrap, then a zero-length job.
        push_n(3);
        begin_job(12'h7FE, 3);
        finish_job();
        begin_job(12'h123, 0);
        finish_job();
        chk("zero_wr_count", wr_count, 11'd0);

        // Abort after five pops leaves three vectors queued.
        fifo_q.delete();
        push_n(8);
        begin_job(12'h040, 8);
        for (int i = 0; i < 5; i++) cycle(1'b0, 0, 0, 1'b0, 1'b0, 1'b1);
        cycle(1'b0, 0, 0, 1'b1, 1'b0, 1'b1);
        finish_job();
        chk("abort_wr_count", wr_count, 11'd5);
        chk("abort_fifo_left", fifo_q.size(), 3);

        // Asynchronous reset in the middle of a job.
        fifo_q.delete();
        push_n(8);
        begin_job(12'h200, 8);
        cycle(1'b0, 0, 0, 1'b0, 1'b0, 1'b1);
        cycle(1'b0, 0, 0, 1'b0, 1'b0, 1'b1);
        #2;
        reset = 1'b0;
        #1;
        chk_reset_values();
        m_drain = 1'b0; m_flush = 1'b0; m_pops = 0; m_left = 0;
        fifo_q.delete();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_hold_cen", wbif.sram_cen, 1'b1);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        push_n(1);
        begin_job(12'h100, 1);
        finish_job();

        // A start while draining must be ignored.
        push_n(4);
        begin_job(12'h300, 4);
        cycle(1'b1, 12'h050, 2, 1'b0, 1'b0, 1'b1);
        finish_job();
        chk("busy_start_wr_count", wr_count, 11'd4);

        // Randomized jobs with random valid, SRAM-busy and abort.
        for (int j = 0; j < 8; j++) begin
            fifo_q.delete();
            n = $urandom_range(1, 6);
            push_n(n + 2);
            begin_job($urandom_range(0, 2047), n);
            for (int k = 0; k < 60 && m_drain; k++) begin
                ve = ($urandom_range(0, 3) != 0);
                sb = ($urandom_range(0, 3) == 0);
                ab = ($urandom_range(0, 15) == 0);
                cycle(1'b0, 0, 0, ab, sb, ve);
            end
            finish_job();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
